// File: rtl/shift_arb_serializer.sv
// shift_arb_serializer
//   Two-requester round-robin arbiter that feeds one shared shift chain.
//   An accepted word is emitted MSB first on o_data. o_frame is high for the
//   WIDTH bit cycles. One idle gap cycle follows each word.
//
// Ports
//   CLK, RST_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/data/ready valid/ready word inputs for requesters 0 and 1
//   o_data                serial bit, 0 outside a frame
//   o_frame               high while o_data carries a valid bit
//   o_src                 index of the requester whose word is being shifted
//   o_busy                high whenever the FSM is not IDLE
module shift_arb_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             o_data,
  output logic             o_frame,
  output logic             o_src,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0] chain_shift;
  logic [CW-1:0]    count_reg;
  logic             last_reg;
  logic             src_reg;
  logic             frame_reg;
  logic             busy_reg;

  logic             grant_valid;
  logic             grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             accept;

  // A tie goes to the requester that did not win last time. A lone
  // requester always wins, whatever the pointer says.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_reg;
    end else begin
      grant_idx = req1_valid;
    end
    grant_data = grant_idx ? req1_data : req0_data;
  end

  assign req0_ready = (state_reg == IDLE) && grant_valid && !grant_idx;
  assign req1_ready = (state_reg == IDLE) && grant_valid &&  grant_idx;
  assign accept     = req0_ready | req1_ready;

  // Left shift by one, filling the LSB with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign chain_shift[gi] = 1'b0;
      end else begin : g_bit
        assign chain_shift[gi] = chain_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= IDLE;
      chain_reg <= '0;
      count_reg <= '0;
      last_reg  <= 1'b1;
      src_reg   <= 1'b0;
      frame_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            chain_reg <= grant_data;
            src_reg   <= grant_idx;
            last_reg  <= grant_idx;
            count_reg <= '0;
            frame_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          chain_reg <= chain_shift;
          if (count_reg == CW'(WIDTH - 1)) begin
            count_reg <= '0;
            frame_reg <= 1'b0;
            state_reg <= GAP;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        GAP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          frame_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The chain MSB is the current bit. Gating it with the frame flag keeps
  // the line quiet outside SHIFT.
  assign o_data  = frame_reg & chain_reg[WIDTH-1];
  assign o_frame = frame_reg;
  assign o_src   = src_reg;
  assign o_busy  = busy_reg;

endmodule

// File: tb/tb_shift_arb_serializer.sv
// Testbench for shift_arb_serializer.
// Instance u_dut uses WIDTH=8. Instance u_w2 uses WIDTH=2.
// A negedge monitor reassembles each 8-bit frame and checks it against
// words queued when stimulus was driven.
module tb_shift_arb_serializer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       o_data, o_frame, o_src, o_busy;

  logic       b_valid0, b_valid1, b_ready0, b_ready1;
  logic [1:0] b_data0, b_data1;
  logic       b_data, b_frame, b_src, b_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       src;
    logic [7:0] data;
  } word_t;

  typedef struct {
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         exp_r0;
    bit         exp_r1;
  } vec_t;

  word_t sb[$];
  int    starts[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_arb_serializer #(.WIDTH(8)) u_dut (
    .CLK(clk), .RST_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .o_data(o_data), .o_frame(o_frame), .o_src(o_src), .o_busy(o_busy)
  );

  shift_arb_serializer #(.WIDTH(2)) u_w2 (
    .CLK(clk), .RST_n(rst_n),
    .req0_valid(b_valid0), .req0_data(b_data0), .req0_ready(b_ready0),
    .req1_valid(b_valid1), .req1_data(b_data1), .req1_ready(b_ready1),
    .o_data(b_data), .o_frame(b_frame), .o_src(b_src), .o_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor state for the WIDTH=8 instance.
  int         cyc = 0;
  int         mon_n = 0;
  logic [7:0] mon_bits = '0;
  logic       mon_src = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_n = 0;
    end else begin
      cyc++;
      if (o_frame) begin
        if (mon_n == 0) begin
          starts.push_back(cyc);
        end else begin
          chk("src_stable", o_src, mon_src);
        end
        mon_src  = o_src;
        mon_bits = {mon_bits[6:0], o_data};
        mon_n++;
        if (mon_n == 8) begin
          mon_n = 0;
          if (sb.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            word_t w;
            w = sb.pop_front();
            chk("word_data", mon_bits, w.data);
            chk("word_src", mon_src, w.src);
            $display("word src=%0d data=%02h expected src=%0d data=%02h",
                     mon_src, mon_bits, w.src, w.data);
          end
        end
      end else begin
        chk("data_idle", o_data, 0);
        if (mon_n != 0) begin
          chk("frame_len", mon_n, 8);
          mon_n = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Call this right after a negedge with the inputs already driven. It
  // counts accepts, one per IDLE cycle with valid&&ready. It returns at
  // the negedge after the n-th accept edge. With drop set, it deasserts
  // both valids there.
  task automatic wait_accepts(input int n, input bit drop);
    int acc = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc++;
      if (acc >= n) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    chk("accept_count", acc, n);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((o_busy || sb.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_busy", o_busy, 0);
    chk("drain_queue", sb.size(), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 8'hA5, 8'h00, 1, 0};
    vecs[1] = '{1, 1, 8'h3C, 8'hC3, 0, 1};
    vecs[2] = '{1, 1, 8'h5A, 8'h99, 1, 0};
    vecs[3] = '{0, 1, 8'h00, 8'h81, 0, 1};
    vecs[4] = '{0, 1, 8'h00, 8'h7E, 0, 1};
    vecs[5] = '{1, 1, 8'h12, 8'h34, 1, 0};
    vecs[6] = '{0, 0, 8'hEE, 8'hDD, 0, 0};
    vecs[7] = '{1, 0, 8'hFF, 8'h00, 1, 0};

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    b_valid0 = 0; b_valid1 = 0; b_data0 = '0; b_data1 = '0;

    // Check the outputs while reset is held.
    #2;
    chk("rst_frame", o_frame, 0);
    chk("rst_data", o_data, 0);
    chk("rst_src", o_src, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_w2_busy", b_busy, 0);
    do_reset();

    // Table-driven grant sequence; each entry starts from IDLE.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      req0_data  = vecs[i].d0; req1_data  = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].exp_r0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].exp_r1);
      if (vecs[i].exp_r0) sb.push_back('{1'b0, vecs[i].d0});
      if (vecs[i].exp_r1) sb.push_back('{1'b1, vecs[i].d1});
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].exp_r0 | vecs[i].exp_r1);
      $display("vec %0d v0=%0d v1=%0d ready0=%0d ready1=%0d", i,
               vecs[i].v0, vecs[i].v1, vecs[i].exp_r0, vecs[i].exp_r1);
      wait_drain();
    end

    // Both requesters hold valid from reset: expect order 0,1,0,1, with
    // frames starting 10 cycles apart.
    do_reset();
    starts.delete();
    req0_data = 8'h0F; req1_data = 8'hF0;
    req0_valid = 1; req1_valid = 1;
    sb.push_back('{1'b0, 8'h0F}); sb.push_back('{1'b1, 8'hF0});
    sb.push_back('{1'b0, 8'h0F}); sb.push_back('{1'b1, 8'hF0});
    wait_accepts(4, 1);
    wait_drain();
    chk("rr_frames", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++) begin
      chk($sformatf("rr_spacing%0d", i), starts[i] - starts[i-1], 10);
    end

    // Change the data while SHIFT is in progress. The first word keeps
    // its latched value. The still-valid request then sends the new word.
    @(negedge clk);
    req0_data = 8'hC6; req0_valid = 1;
    sb.push_back('{1'b0, 8'hC6});
    wait_accepts(1, 0);
    repeat (3) @(negedge clk);
    req0_data = 8'h39;
    sb.push_back('{1'b0, 8'h39});
    wait_accepts(1, 1);
    wait_drain();

    // Assert reset after the 3rd bit of 8'hFF. The frame must abort at
    // once, and the next tie must go to requester 0.
    @(negedge clk);
    req0_data = 8'hFF; req0_valid = 1;
    sb.push_back('{1'b0, 8'hFF});
    wait_accepts(1, 1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_frame", o_frame, 0);
    chk("abort_data", o_data, 0);
    chk("abort_busy", o_busy, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    req0_data = 8'h96; req1_data = 8'h69;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    sb.push_back('{1'b0, 8'h96});
    wait_accepts(1, 1);
    wait_drain();

    // WIDTH=2 build: 2'b10 held valid. Expect a 2-cycle frame of 1,0 and a
    // 4-cycle period.
    @(negedge clk);
    b_data0 = 2'b10; b_valid0 = 1;
    #1;
    chk("w2_ready0", b_ready0, 1);
    begin
      logic [7:0] exp_frame;
      logic [7:0] exp_bits;
      exp_frame = 8'b1100_1100;
      exp_bits  = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk($sformatf("w2_frame%0d", i), b_frame, exp_frame[7-i]);
        chk($sformatf("w2_data%0d", i), b_data, exp_bits[7-i]);
        $display("w2 cycle %0d frame=%0d data=%0d", i, b_frame, b_data);
      end
    end
    b_valid0 = 0;
    repeat (4) @(negedge clk);
    chk("w2_idle", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_arb_serializer.md
SHIFT_ARB_SERIALIZER -- requirements
Module: shift_arb_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RST_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 holds a word.
REQ-005 req0_data  input  WIDTH  requester 0 word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle when valid is also high.
REQ-007 req1_valid  input  1  requester 1 holds a word.
REQ-008 req1_data  input  WIDTH  requester 1 word.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle when valid is also high.
REQ-010 o_data  output  1  serial bit stream, MSB first.
REQ-011 o_frame  output  1  high while o_data carries a valid bit.
REQ-012 o_src  output  1  requester index of the word being shifted; held stable through the frame.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement a shared WIDTH-stage shift chain, a bit counter and a 3-state FSM: IDLE, SHIFT, GAP.
REQ-015 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester; the other ready SHALL be low; in SHIFT and GAP, both readies SHALL be low.
REQ-016 Grant: only one requester valid -> that one; both valid -> the requester not granted last (round-robin); after reset, requester 0 counts as not-last, so it wins the first tie.
REQ-017 Transfer occurs on an edge in IDLE with the granted valid&&ready; the chain loads reqN_data, o_src latches N, the last-grant pointer updates, and the FSM enters SHIFT.
REQ-018 In SHIFT, o_frame SHALL be 1 and o_data SHALL equal chain[WIDTH-1]; each edge shifts the chain left by one, filling with 0, and increments the counter.
REQ-019 For a transfer at edge k, o_frame SHALL be high in exactly the cycles after edges k+1-1 .. k+WIDTH-1, i.e. the WIDTH cycles immediately following edge k; bit (WIDTH-1-i) SHALL be on o_data in the i-th such cycle.
REQ-020 After WIDTH bits, the FSM SHALL enter GAP for exactly one cycle with o_frame=0, then return to IDLE.
REQ-021 Minimum period per word: WIDTH+2 cycles (accept, WIDTH shift, gap); no bubble beyond the GAP state when a request is pending.
REQ-022 Outside SHIFT, o_frame SHALL be 0 and o_data SHALL be 0.
REQ-023 A deasserted valid during SHIFT/GAP SHALL have no effect; data changes on an unaccepted request SHALL not be sampled.
REQ-024 A requester holding valid continuously SHALL be granted at least every second word while the other also holds valid (no starvation).

Reset
REQ-025 While RST_n=0: FSM=IDLE, chain=0, counter=0, last-grant=1 (so requester 0 wins the first tie), o_data=0, o_frame=0, o_src=0, o_busy=0.
REQ-026 Reset asserted mid-frame SHALL abort immediately; no remaining bits are emitted, and the aborted word is lost.
REQ-027 After RST_n rises, the first accept SHALL occur no earlier than the first rising edge with RST_n high.

Verification
REQ-028 WIDTH=8, only req0 valid with data 8'hA5 -> req0_ready=1 in IDLE; o_data = 1,0,1,0,0,1,0,1 over 8 frame cycles; o_src=0; one GAP cycle.
REQ-029 Both valid from reset, data0=8'h0F and data1=8'hF0 -> order req0, req1, req0, req1; words spaced exactly 10 cycles apart.
REQ-030 req1 alone valid after a req1 grant -> req1 granted again immediately after GAP; round-robin does not block a lone requester.
REQ-031 RST_n pulsed low after the 3rd bit of 8'hFF -> o_frame drops asynchronously; after release the FSM is in IDLE and the next tie goes to req0.
REQ-032 req0_data changed while SHIFT is in progress -> serial output still matches the word latched at accept.
REQ-033 WIDTH=2 build, req0 data 2'b10 -> frame of 2 cycles carrying 1,0; period 4 cycles.
